// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - opcodes, ALU_OP codes, FSM states and select encodings for the RV32I multi-cycle control unit
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_IMM = 2'b01;
    localparam logic [1:0] WD_MEM = 2'b10;
    localparam logic [1:0] WD_PC  = 2'b11;

    localparam logic PC_PLUS4  = 1'b0;
    localparam logic PC_TARGET = 1'b1;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [2:0] {
        CLS_R, CLS_IARITH, CLS_LUI, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILL
    } op_class_t;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_WB_LUI, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BR, S_JMP, S_TRAP
    } state_t;

    function automatic logic [2:0] imm_type_of(input op_class_t c);
        case (c)
            CLS_STORE:  return IMM_S;
            CLS_BRANCH: return IMM_B;
            CLS_LUI:    return IMM_U;
            CLS_JAL:    return IMM_J;
            default:    return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/rv32_inst_decode.sv
// rtl/rv32_inst_decode.sv - combinational opcode classification, ALU_OP selection and legality check
module rv32_inst_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output op_class_t   op_class,
    output logic [3:0]  alu_op,
    output logic        legal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       f7_zero;
    logic       f7_alt;
    logic       unused_inst_bits;

    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign funct7  = inst[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);
    assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

    always_comb begin
        op_class = CLS_ILL;
        alu_op   = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OPC_R: begin
                op_class = CLS_R;
                alu_op   = {inst[30], funct3};
                legal    = f7_zero | (f7_alt & ((funct3 == 3'b000) | (funct3 == 3'b101)));
            end
            OPC_IARITH: begin
                op_class = CLS_IARITH;
                // only the shifts carry a funct7 field; elsewhere bit 30 is immediate data
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    alu_op = {inst[30], funct3};
                    legal  = f7_zero | (f7_alt & (funct3 == 3'b101));
                end else begin
                    alu_op = {1'b0, funct3};
                    legal  = 1'b1;
                end
            end
            OPC_LUI: begin
                op_class = CLS_LUI;
                legal    = 1'b1;
            end
            OPC_LOAD: begin
                op_class = CLS_LOAD;
                legal    = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                op_class = CLS_STORE;
                legal    = (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                op_class = CLS_BRANCH;
                alu_op   = ALU_SUB;
                legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            OPC_JAL: begin
                op_class = CLS_JAL;
                legal    = 1'b1;
            end
            default: ;
        endcase
        if (!legal) begin
            op_class = CLS_ILL;
            alu_op   = ALU_ADD;
        end
    end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// rtl/rv32_mc_ctrl.sv - multi-cycle RV32I control FSM with registered strobes, selects and ALU_OP
module rv32_mc_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        ZF,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic        PC0_Write,
    output logic        Reg_Write,
    output logic        Mem_Write,
    output logic [3:0]  ALU_OP,
    output logic        rs2_imm_s,
    output logic [1:0]  w_data_s,
    output logic        pc_s,
    output logic [2:0]  imm_type,
    output logic        illegal
);

    op_class_t dec_class;
    logic [3:0] dec_alu_op;
    logic       dec_legal;

    rv32_inst_decode u_decode (
        .inst     (inst),
        .op_class (dec_class),
        .alu_op   (dec_alu_op),
        .legal    (dec_legal)
    );

    state_t     state_q, state_d;
    op_class_t  cls_q, cls_d;
    logic       bne_q, bne_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [2:0] imm_type_q, imm_type_d;
    logic       ir_write_q, ir_write_d;
    logic       pc_write_q, pc_write_d;
    logic       pc0_write_q, pc0_write_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_write_q, mem_write_d;
    logic       rs2_imm_s_q, rs2_imm_s_d;
    logic [1:0] w_data_s_q, w_data_s_d;
    logic       pc_s_q, pc_s_d;
    logic       illegal_q, illegal_d;
    logic       br_taken;

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        bne_d      = bne_q;
        alu_op_d   = alu_op_q;
        imm_type_d = imm_type_q;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                cls_d      = dec_class;
                bne_d      = inst[12];
                alu_op_d   = dec_alu_op;
                imm_type_d = imm_type_of(dec_class);
                case (dec_class)
                    CLS_R, CLS_IARITH:    state_d = S_EXEC;
                    CLS_LUI:              state_d = S_WB_LUI;
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM_ADDR;
                    CLS_BRANCH:           state_d = S_BR;
                    CLS_JAL:              state_d = S_JMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
                    end
                endcase
            end
            S_EXEC:     state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (cls_q == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_WB_MEM;
            S_WB_ALU, S_WB_LUI, S_WB_MEM, S_MEM_WR, S_BR, S_JMP: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase

        // outputs are registered, so they are decoded from the state being entered
        ir_write_d  = (state_d == S_FETCH);
        pc0_write_d = (state_d == S_FETCH);
        pc_write_d  = (state_d == S_FETCH) || (state_d == S_JMP);
        pc_s_d      = ((state_d == S_BR) || (state_d == S_JMP)) ? PC_TARGET : PC_PLUS4;
        reg_write_d = (state_d inside {S_WB_ALU, S_WB_LUI, S_WB_MEM, S_JMP});
        mem_write_d = (state_d == S_MEM_WR);
        // ALU_B stays on the immediate through the whole sequence so ALU_F is stable at write time
        rs2_imm_s_d = ((state_d inside {S_EXEC, S_WB_ALU}) && (cls_d == CLS_IARITH)) ||
                      (state_d inside {S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM});
        case (state_d)
            S_WB_LUI: w_data_s_d = WD_IMM;
            S_WB_MEM: w_data_s_d = WD_MEM;
            S_JMP:    w_data_s_d = WD_PC;
            default:  w_data_s_d = WD_ALU;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cls_q       <= CLS_R;
            bne_q       <= 1'b0;
            alu_op_q    <= ALU_ADD;
            imm_type_q  <= IMM_I;
            ir_write_q  <= 1'b0;
            pc_write_q  <= 1'b0;
            pc0_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            rs2_imm_s_q <= 1'b0;
            w_data_s_q  <= WD_ALU;
            pc_s_q      <= PC_PLUS4;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            bne_q       <= bne_d;
            alu_op_q    <= alu_op_d;
            imm_type_q  <= imm_type_d;
            ir_write_q  <= ir_write_d;
            pc_write_q  <= pc_write_d;
            pc0_write_q <= pc0_write_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            rs2_imm_s_q <= rs2_imm_s_d;
            w_data_s_q  <= w_data_s_d;
            pc_s_q      <= pc_s_d;
            illegal_q   <= illegal_d;
        end
    end

    // ZF only settles once the ALU sees the branch operands, so the taken term is combinational
    assign br_taken  = (state_q == S_BR) && (bne_q ? ~ZF : ZF);

    assign IR_Write  = ir_write_q;
    assign PC_Write  = pc_write_q | br_taken;
    assign PC0_Write = pc0_write_q;
    assign Reg_Write = reg_write_q;
    assign Mem_Write = mem_write_q;
    assign ALU_OP    = alu_op_q;
    assign rs2_imm_s = rs2_imm_s_q;
    assign w_data_s  = w_data_s_q;
    assign pc_s      = pc_s_q;
    assign imm_type  = imm_type_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// tb/tb_rv32_mc_ctrl.sv - directed and random instruction streams checked against an instruction-level model
module tb_rv32_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        ZF = 1'b0;
    logic        IR_Write, PC_Write, PC0_Write, Reg_Write, Mem_Write;
    logic [3:0]  ALU_OP;
    logic        rs2_imm_s, pc_s, illegal;
    logic [1:0]  w_data_s;
    logic [2:0]  imm_type;

    int    n_checks = 0;
    int    n_errors = 0;
    string ctx = "reset";

    rv32_mc_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst      (inst),
        .ZF        (ZF),
        .IR_Write  (IR_Write),
        .PC_Write  (PC_Write),
        .PC0_Write (PC0_Write),
        .Reg_Write (Reg_Write),
        .Mem_Write (Mem_Write),
        .ALU_OP    (ALU_OP),
        .rs2_imm_s (rs2_imm_s),
        .w_data_s  (w_data_s),
        .pc_s      (pc_s),
        .imm_type  (imm_type),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] len;
        logic [3:0] wb_k;
        logic [1:0] wb_sel;
        logic [3:0] mw_k;
        logic       pcw3;
        logic       pcs3;
        logic [3:0] alu;
        logic       chk_imm;
        logic [2:0] imm;
        logic       chk_b;
        logic       b_sel;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s [%s]: observed %0h expected %0h", tag, ctx, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        ctx = tag;
        chk("IR_Write", IR_Write, 0);
        chk("PC_Write", PC_Write, 0);
        chk("PC0_Write", PC0_Write, 0);
        chk("Reg_Write", Reg_Write, 0);
        chk("Mem_Write", Mem_Write, 0);
        chk("ALU_OP", ALU_OP, 0);
        chk("rs2_imm_s", rs2_imm_s, 0);
        chk("w_data_s", w_data_s, 0);
        chk("pc_s", pc_s, 0);
        chk("imm_type", imm_type, 0);
        chk("illegal", illegal, 0);
    endtask

    // Instruction-level expectations: cycle 1 is FETCH, cycle 2 DECODE, events counted from there.
    function automatic exp_t model(input logic [31:0] i, input logic zf);
        exp_t e;
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        e = '0;
        case (op)
            7'h33: begin
                e.len = 4; e.wb_k = 4; e.wb_sel = 2'd0; e.chk_b = 1; e.b_sel = 0;
                e.alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd8 : 4'd13) : {1'b0, f3};
            end
            7'h13: begin
                e.len = 4; e.wb_k = 4; e.wb_sel = 2'd0; e.chk_b = 1; e.b_sel = 1;
                e.chk_imm = 1; e.imm = 3'd0;
                e.alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'd13 : {1'b0, f3};
            end
            7'h37: begin
                e.len = 3; e.wb_k = 3; e.wb_sel = 2'd1; e.chk_imm = 1; e.imm = 3'd3; e.alu = 4'd0;
            end
            7'h03: begin
                e.len = 5; e.wb_k = 5; e.wb_sel = 2'd2; e.chk_b = 1; e.b_sel = 1;
                e.chk_imm = 1; e.imm = 3'd0; e.alu = 4'd0;
            end
            7'h23: begin
                e.len = 4; e.mw_k = 4; e.chk_b = 1; e.b_sel = 1;
                e.chk_imm = 1; e.imm = 3'd1; e.alu = 4'd0;
            end
            7'h63: begin
                e.len = 3; e.pcw3 = (f3 == 3'd0) ? zf : !zf; e.pcs3 = 1;
                e.chk_b = 1; e.b_sel = 0; e.chk_imm = 1; e.imm = 3'd2; e.alu = 4'd8;
            end
            default: begin
                e.len = 3; e.wb_k = 3; e.wb_sel = 2'd3; e.pcw3 = 1; e.pcs3 = 1;
                e.chk_imm = 1; e.imm = 3'd4; e.alu = 4'd0;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        logic [2:0]  f3 = r[14:12];
        logic [6:0]  f7;
        case ($urandom_range(0, 6))
            0: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[31]) ? 7'h20 : 7'h00;
                return {f7, r[24:15], f3, r[11:7], 7'h33};
            end
            1: begin
                if (f3 == 3'd1)      f7 = 7'h00;
                else if (f3 == 3'd5) f7 = r[31] ? 7'h20 : 7'h00;
                else                 f7 = r[31:25];
                return {f7, r[24:15], f3, r[11:7], 7'h13};
            end
            2: return {r[31:7], 7'h37};
            3: return {r[31:15], 3'b010, r[11:7], 7'h03};
            4: return {r[31:15], 3'b010, r[11:7], 7'h23};
            5: return {r[31:15], 2'b00, r[12], r[11:7], 7'h63};
            default: return {r[31:7], 7'h6F};
        endcase
    endfunction

    task automatic run_inst(input logic [31:0] i, input logic zf, input int stop_k);
        exp_t e = model(i, zf);
        int n = (stop_k < int'(e.len)) ? stop_k : int'(e.len);
        inst = i;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            ZF = (k == 3 && i[6:0] == 7'h63) ? zf : 1'($urandom);
            @(negedge clk);
            ctx = $sformatf("inst=%08h cycle=%0d", i, k);
            chk("IR_Write", IR_Write, k == 1);
            chk("PC0_Write", PC0_Write, k == 1);
            chk("PC_Write", PC_Write, (k == 1) || (k == 3 && e.pcw3));
            chk("Reg_Write", Reg_Write, k == int'(e.wb_k));
            chk("Mem_Write", Mem_Write, k == int'(e.mw_k));
            chk("illegal", illegal, 0);
            if (k == 1) chk("pc_s", pc_s, 0);
            if (k == 3 && e.pcs3) chk("pc_s", pc_s, 1);
            if (k == int'(e.wb_k)) chk("w_data_s", w_data_s, e.wb_sel);
            if (k >= 3) chk("ALU_OP", ALU_OP, e.alu);
            if (k >= 3 && e.chk_imm) chk("imm_type", imm_type, e.imm);
            if (k == 3 && e.chk_b) chk("rs2_imm_s", rs2_imm_s, e.b_sel);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_inst(32'h002081B3, 1'b0, 99);
        run_inst(32'h4032D293, 1'b0, 99);
        run_inst(32'h403100B3, 1'b0, 99);
        run_inst(32'h00802203, 1'b0, 99);
        run_inst(32'h00402623, 1'b0, 99);
        run_inst(32'h00208463, 1'b1, 99);
        run_inst(32'h00208463, 1'b0, 99);
        run_inst(32'h00209463, 1'b0, 99);
        run_inst(32'h00209463, 1'b1, 99);
        run_inst(32'h010000EF, 1'b0, 99);
        run_inst(32'h123453B7, 1'b0, 99);

        repeat (40) run_inst(rand_inst(), 1'($urandom), 99);

        // reset lands while the load sits in MEM_RD
        run_inst(32'h00802203, 1'b0, 4);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async reset in MEM_RD");
        @(negedge clk);
        chk_all_zero("reset held");
        rst_n = 1'b1;
        run_inst(32'h00802203, 1'b0, 99);

        inst = 32'hFFFFFFFF;
        @(negedge clk);
        ctx = "illegal fetch";
        chk("IR_Write", IR_Write, 1);
        @(negedge clk);
        ctx = "illegal decode";
        chk("illegal", illegal, 0);
        chk("Reg_Write", Reg_Write, 0);
        @(negedge clk);
        ctx = "illegal pulse";
        chk("illegal", illegal, 1);
        chk("PC_Write", PC_Write, 0);
        chk("Reg_Write", Reg_Write, 0);
        chk("Mem_Write", Mem_Write, 0);
        for (int c = 0; c < 20; c++) begin
            ZF = 1'($urandom);
            @(negedge clk);
            ctx = $sformatf("trap cycle %0d", c);
            chk("illegal", illegal, 0);
            chk("strobes", {IR_Write, PC_Write, PC0_Write, Reg_Write, Mem_Write}, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32_mc_ctrl.md
Name: rv32_mc_ctrl

Overview:
- Multi-cycle control unit for the lab RV32I core; the producer side of the ALU_OP/flag interface consumed by the datapath ALU.
- Sequences fetch/decode/execute/memory/writeback with a Moore FSM.
- Decodes the instruction register and drives ALU_OP, register-file, memory and PC strobes.
- Consumes the ALU zero flag for conditional branches.

Parameters:
- HALT_ON_ILLEGAL, 1, 1: an illegal instruction parks the FSM in TRAP until reset; 0: pulse illegal and refetch.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- inst  in  32  IR contents; stable from the cycle after FETCH until the next FETCH.
- ZF  in  1  ALU zero flag, combinational from the current ALU_OP and operands.
- IR_Write  out  1  load IR from instruction memory.
- PC_Write  out  1  load PC from the pc_s mux.
- PC0_Write  out  1  save the current PC into PC0, the instruction address.
- Reg_Write  out  1  register file write of rd.
- Mem_Write  out  1  data memory write.
- ALU_OP  out  4  ALU operation; registered.
- rs2_imm_s  out  1  ALU_B select: 0 = rs2, 1 = immediate.
- w_data_s  out  2  rd source: 00 = ALU_F, 01 = imm (LUI), 10 = memory read data, 11 = PC (already PC0+4).
- pc_s  out  1  PC source: 0 = PC+4, 1 = PC0+imm.
- imm_type  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J.
- illegal  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. All strobes, ALU_OP, every select, imm_type and illegal are 0.
- IDLE goes to FETCH on the first clock after reset release.
- All outputs except ALU_OP are decoded from the state and from the opcode class latched at DECODE. Strobes are high for exactly one cycle per state.
- FETCH:
  - Asserts IR_Write, PC_Write with pc_s = 0, and PC0_Write.
  - Next state is DECODE.
- DECODE:
  - Classifies inst[6:0] as R (0110011), IARITH (0010011), LUI (0110111), LOAD (0000011, funct3 010), STORE (0100011, funct3 010), BRANCH (1100011, funct3 000/001), JAL (1101111).
  - Loads ALU_OP. imm_type becomes valid from the cycle after DECODE.
- ALU_OP loaded at DECODE:
  - R: {inst[30], funct3}. Legal only if funct7 = 0000000, or 0100000 with funct3 000 or 101.
  - IARITH, funct3 = 001 or 101: {inst[30], funct3}. funct7 must be 0000000, or 0100000 with funct3 101.
  - IARITH, other funct3: {0, funct3}.
  - LOAD, STORE, JAL, LUI: 0000 (add).
  - BRANCH: 1000 (sub).
  - ALU_OP holds its value until the next DECODE.
- Sequences after DECODE; total latency includes FETCH and DECODE:
  - R / IARITH: EXEC (rs2_imm_s = 0 / 1) -> WB_ALU (Reg_Write, w_data_s = 00) -> FETCH. 4 cycles.
  - LUI: WB_LUI (Reg_Write, w_data_s = 01, imm_type U) -> FETCH. 3 cycles.
  - LOAD: MEM_ADDR (rs2_imm_s = 1, imm I) -> MEM_RD -> WB_MEM (Reg_Write, w_data_s = 10) -> FETCH. 5 cycles.
  - STORE: MEM_ADDR (imm S) -> MEM_WR (Mem_Write) -> FETCH. 4 cycles.
  - BRANCH: BR (rs2_imm_s = 0, imm B, pc_s = 1). PC_Write = (BEQ & ZF) | (BNE & ~ZF). Then FETCH. 3 cycles.
  - JAL: JMP (Reg_Write, w_data_s = 11, PC_Write, pc_s = 1, imm J) -> FETCH. 3 cycles. The rd write and the PC load occur in the same edge.
- Illegal instruction at DECODE:
  - illegal pulses during the cycle after DECODE.
  - No Reg_Write, Mem_Write or PC_Write is asserted for that instruction.
  - Next state is TRAP if HALT_ON_ILLEGAL = 1, else FETCH.
  - TRAP holds all strobes at 0 until reset.
- rd = x0: the controller still asserts Reg_Write; the register file discards the write.
- ZF is sampled only in BR and ignored elsewhere.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. No partial write may complete after reset assertion.
- State encoding: one-hot or binary, implementer's choice. Unused encodings recover to IDLE.

Decomposition:
- Package rv32_ctrl_pkg holds:
  - opcode constants;
  - ALU_OP codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101;
  - state enum;
  - w_data_s, pc_s and imm_type constants.
- One sub-module, rv32_inst_decode: combinational; produces opcode class, next ALU_OP and the legal flag.
- The FSM and registered outputs live in rv32_mc_ctrl.

Test Plan:
- Reset then inst = add x3,x1,x2 (0x002081B3):
  - FETCH/DECODE/EXEC/WB take 4 cycles.
  - ALU_OP = 0000; Reg_Write high only in WB with w_data_s = 00; IR_Write and PC_Write pulse only in FETCH.
- srai x5,x5,3 (0x4032D293) -> ALU_OP = 1101, rs2_imm_s = 1, imm_type I. Then sub x1,x2,x3 (0x403100B3) -> ALU_OP = 1000.
- lw x4,8(x0) -> 5-cycle sequence, Reg_Write with w_data_s = 10 in cycle 5. Then sw x4,12(x0) -> Mem_Write for exactly 1 cycle in cycle 4, no Reg_Write.
- Branches:
  - beq with ZF = 1 -> PC_Write and pc_s = 1 in BR.
  - beq with ZF = 0 -> no PC_Write in BR.
  - bne with ZF = 0 -> PC_Write.
  - Each takes 3 cycles.
- jal x1,+16 -> cycle 3 asserts Reg_Write (w_data_s = 11), PC_Write (pc_s = 1) and imm_type J together. lui x7,0x12345 -> Reg_Write with w_data_s = 01 in cycle 3.
- Error and reset cases:
  - inst = 0xFFFFFFFF with HALT_ON_ILLEGAL = 1 -> illegal pulses once, then all strobes stay 0 for 20 cycles.
  - rst_n low mid-LOAD (MEM_RD) -> outputs 0 asynchronously; the next instruction restarts at IDLE -> FETCH.
